// File: rtl/alu_mdu.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// Start/Ready handshake, one-cycle Done pulse, registered Result/Zero and Kill abort.
module alu_mdu #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 3,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Start,
  input  logic                  Kill,
  input  logic [OP_WIDTH-1:0]   MDUOp,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  Ready,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Zero
);
  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(W - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic                  neg_q, neg_d;
  logic [W-1:0]          b_mag_q, b_mag_d;
  logic [2*W-1:0]        acc_q, acc_d;
  logic [W:0]            rem_q, rem_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [W-1:0]          result_q, result_d;
  logic                  zero_q, zero_d;

  logic           accept, in_div, sign_a, sign_b, b_zero, ovf, fast;
  logic [W-1:0]   a_mag, b_mag, fast_val, fix_val, quo, remv;
  logic [2*W-1:0] prod;
  logic [W:0]     shifted, sum;

  // Operand decode for the incoming request
  always_comb begin
    in_div   = MDUOp[2];
    sign_a   = SrcA[W-1] & (in_div ? ~MDUOp[0] : (MDUOp[1:0] != 2'b11));
    sign_b   = SrcB[W-1] & (in_div ? ~MDUOp[0] : ~MDUOp[1]);
    a_mag    = sign_a ? -SrcA : SrcA;
    b_mag    = sign_b ? -SrcB : SrcB;
    b_zero   = (SrcB == '0);
    ovf      = in_div && !MDUOp[0] && (SrcA == MOST_NEG) && (SrcB == '1);
    fast     = in_div && (b_zero || ovf);
    fast_val = b_zero ? (MDUOp[1] ? SrcA : '1) : (MDUOp[1] ? '0 : SrcA);
    accept   = Start && Ready && !Kill;
  end

  // Sign correction and field select for the FIX cycle
  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    quo  = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    remv = neg_q ? -rem_q[W-1:0] : rem_q[W-1:0];
    if (op_q[2])
      fix_val = op_q[1] ? remv : quo;
    else
      fix_val = (op_q[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
  end

  always_comb begin
    state_d = state_q;
    if (Kill) state_d = S_IDLE;
    else begin
      case (state_q)
        S_IDLE, S_DONE: state_d = Start ? (fast ? S_DONE : S_CALC) : S_IDLE;
        S_CALC:         if (cnt_q == LAST_ITER) state_d = S_FIX;
        S_FIX:          state_d = S_DONE;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    Ready = (state_q == S_IDLE) || (state_q == S_DONE);
    Busy  = (state_q == S_CALC) || (state_q == S_FIX);
    Done  = (state_q == S_DONE);
  end

  always_comb begin
    op_d     = op_q;
    neg_d    = neg_q;
    b_mag_d  = b_mag_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    shifted  = {rem_q[W-1:0], acc_q[W-1]};
    sum      = {1'b0, acc_q[2*W-1:W]} + ({(W+1){acc_q[0]}} & {1'b0, b_mag_q});
    if (accept) begin
      op_d    = MDUOp;
      neg_d   = (in_div && MDUOp[1]) ? sign_a : (sign_a ^ sign_b);
      b_mag_d = b_mag;
      acc_d   = {{W{1'b0}}, a_mag};
      rem_d   = '0;
      cnt_d   = '0;
      if (fast) begin
        result_d = fast_val;
        zero_d   = (fast_val == '0);
      end
    end else if (state_q == S_CALC) begin
      cnt_d = cnt_q + 1'b1;
      if (op_q[2]) begin
        // Restoring step: dividend bits shift from the accumulator low half
        if (shifted >= {1'b0, b_mag_q}) begin
          rem_d = shifted - {1'b0, b_mag_q};
          acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], 1'b1};
        end else begin
          rem_d = shifted;
          acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], 1'b0};
        end
      end else begin
        acc_d = {sum, acc_q[W-1:1]};
      end
    end else if (state_q == S_FIX && !Kill) begin
      result_d = fix_val;
      zero_d   = (fix_val == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q    <= op_d;
    neg_q   <= neg_d;
    b_mag_q <= b_mag_d;
    acc_q   <= acc_d;
    rem_q   <= rem_d;
  end

  assign Result = result_q;
  assign Zero   = zero_q;
endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu (DATA_WIDTH = 32).
module tb_alu_mdu;
  logic        clk = 1'b0;
  logic        rst;
  logic        Start, Kill;
  logic [2:0]  MDUOp;
  logic [31:0] SrcA, SrcB;
  logic        Ready, Busy, Done, Zero;
  logic [31:0] Result;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010,
    OP_MULHU = 3'b011, OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

  alu_mdu #(.DATA_WIDTH(32), .OP_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .Start(Start), .Kill(Kill), .MDUOp(MDUOp),
    .SrcA(SrcA), .SrcB(SrcB), .Ready(Ready), .Busy(Busy), .Done(Done),
    .Result(Result), .Zero(Zero)
  );

  always #5 clk = ~clk;

  // Issues one op and waits (bounded) for Done; lat counts edges after acceptance.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic z, output int lat,
                        output int busy_cyc, output bit timeout, output logic done_after);
    @(negedge clk);
    MDUOp = op; SrcA = a; SrcB = b; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; lat = 0; busy_cyc = 0;
    if (Busy) busy_cyc++;
    while (!Done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (Busy) busy_cyc++;
    end
    timeout = !Done;
    res = Result; z = Zero;
    @(posedge clk); #1;
    done_after = Done;
  endtask

  task automatic test_reset;
    checks++;
    if ({Ready, Busy, Done, Zero} !== 4'b1001 || Result !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got R/B/D/Z=%b Result=%h expected 1001 Result=00000000",
               {Ready, Busy, Done, Zero}, Result);
    end
  endtask

  task automatic test_mul_timing;
    logic [31:0] r; logic z, da; int lat, bc; bit to;
    run_op(OP_MUL, 32'd7, 32'hFFFFFFFD, r, z, lat, bc, to, da);
    checks++;
    if (to) begin errors++; $display("FAIL mul_timeout: Done never seen, expected within 33 edges"); end
    checks++;
    if (r !== 32'hFFFFFFEB || z !== 1'b0) begin
      errors++; $display("FAIL mul_neg: got %h Zero=%b expected ffffffeb Zero=0", r, z);
    end
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL mul_latency: got %0d edges expected 33", lat); end
    checks++;
    if (bc !== 33) begin errors++; $display("FAIL mul_busy: got %0d busy cycles expected 33", bc); end
    checks++;
    if (da !== 1'b0) begin errors++; $display("FAIL mul_done_width: Done still %b one cycle later expected 0", da); end
  endtask

  task automatic test_mul_variants;
    logic [2:0]  ops [4] = '{OP_MULH, OP_MULHU, OP_MULHSU, OP_MUL};
    logic [31:0] as  [4] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010000};
    logic [31:0] bs  [4] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010000};
    logic [31:0] exp [4] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000};
    logic        ez  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] r; logic z, da; int lat, bc; bit to;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], r, z, lat, bc, to, da);
      checks++;
      if (to || r !== exp[i] || z !== ez[i]) begin
        errors++;
        $display("FAIL mul_variant[%0d] op=%b: got %h Zero=%b timeout=%0d expected %h Zero=%b",
                 i, ops[i], r, z, to, exp[i], ez[i]);
      end
    end
  endtask

  task automatic test_div;
    logic [2:0]  ops [4] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU};
    logic [31:0] as  [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
    logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] exp [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
    logic [31:0] r; logic z, da; int lat, bc; bit to;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], r, z, lat, bc, to, da);
      checks++;
      if (to || r !== exp[i] || z !== 1'b0 || lat !== 33) begin
        errors++;
        $display("FAIL div[%0d] op=%b: got %h Zero=%b lat=%0d expected %h Zero=0 lat=33",
                 i, ops[i], r, z, lat, exp[i]);
      end
    end
  endtask

  task automatic test_fast_path;
    logic [2:0]  ops [4] = '{OP_DIVU, OP_REM, OP_DIV, OP_REM};
    logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
    logic        ez  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] r; logic z, da; int lat, bc; bit to;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], r, z, lat, bc, to, da);
      checks++;
      if (to || r !== exp[i] || z !== ez[i] || lat !== 0 || da !== 1'b0) begin
        errors++;
        $display("FAIL fast[%0d] op=%b: got %h Zero=%b lat=%0d doneafter=%b expected %h Zero=%b lat=0 doneafter=0",
                 i, ops[i], r, z, lat, da, exp[i], ez[i]);
      end
    end
  endtask

  task automatic test_kill;
    logic [31:0] r; logic z, da; int lat, bc, seen; bit to;
    run_op(OP_DIVU, 32'd100, 32'd7, r, z, lat, bc, to, da);
    @(negedge clk);
    MDUOp = OP_DIV; SrcA = 32'd1000; SrcB = 32'd3; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); Kill = 1'b1;
    @(posedge clk); #1;
    Kill = 1'b0;
    checks++;
    if (Ready !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0 || Result !== 32'd14) begin
      errors++;
      $display("FAIL kill_state: got Ready=%b Busy=%b Done=%b Result=%h expected 1 0 0 0000000e",
               Ready, Busy, Done, Result);
    end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (Done) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL kill_no_done: got %0d Done cycles expected 0", seen); end
    // Start together with Kill while idle must be ignored
    @(negedge clk); MDUOp = OP_MUL; SrcA = 32'd2; SrcB = 32'd2; Start = 1'b1; Kill = 1'b1;
    @(posedge clk); #1; Start = 1'b0; Kill = 1'b0;
    checks++;
    if (Busy !== 1'b0 || Ready !== 1'b1) begin
      errors++; $display("FAIL kill_blocks_start: got Busy=%b Ready=%b expected 0 1", Busy, Ready);
    end
    run_op(OP_MUL, 32'd3, 32'd4, r, z, lat, bc, to, da);
    checks++;
    if (to || r !== 32'd12) begin
      errors++; $display("FAIL after_kill_mul: got %h timeout=%0d expected 0000000c", r, to);
    end
  endtask

  task automatic test_reset_mid_op;
    @(negedge clk);
    MDUOp = OP_MULHU; SrcA = 32'h12345678; SrcB = 32'h9ABCDEF0; Start = 1'b1;
    @(posedge clk); #1; Start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({Ready, Busy, Done, Zero} !== 4'b1001 || Result !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_op: got R/B/D/Z=%b Result=%h expected 1001 Result=00000000",
               {Ready, Busy, Done, Zero}, Result);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_back_to_back;
    int n1, n2;
    @(negedge clk);
    MDUOp = OP_DIVU; SrcA = 32'd9; SrcB = 32'd3; Start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    MDUOp = OP_REMU; SrcA = 32'd9; SrcB = 32'd4;
    n1 = 1;
    while (!Done && n1 < 100) begin @(posedge clk); #1; if (!Done) n1++; end
    checks++;
    if (!Done || n1 !== 33 || Result !== 32'd3) begin
      errors++; $display("FAIL b2b_first: got Done=%b lat=%0d Result=%h expected 1 33 00000003", Done, n1, Result);
    end
    @(posedge clk); #1;
    Start = 1'b0;
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b1) begin
      errors++; $display("FAIL b2b_accept: got Done=%b Busy=%b expected 0 1", Done, Busy);
    end
    n2 = 0;
    while (!Done && n2 < 100) begin @(posedge clk); #1; n2++; end
    checks++;
    if (!Done || n2 !== 33 || Result !== 32'd1) begin
      errors++; $display("FAIL b2b_second: got Done=%b lat=%0d Result=%h expected 1 33 00000001", Done, n2, Result);
    end
  endtask

  initial begin
    rst = 1'b1; Start = 1'b0; Kill = 1'b0; MDUOp = '0; SrcA = '0; SrcB = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk); rst = 1'b0;
    test_mul_timing;
    test_mul_variants;
    test_div;
    test_fast_path;
    test_kill;
    test_reset_mid_op;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
